// File: rtl/nv_blkbox_pipe_rcv.sv
// nv_blkbox_pipe_rcv: receive-side circular retiming buffer, optional bypass via NV_BLKBOX_PIPE_BYPASS_EN
module nv_blkbox_pipe_rcv #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rst,
  input  logic             in_pvld,
  output logic             in_prdy,
  input  logic [WIDTH-1:0] in_pd,
  output logic             out_pvld,
  input  logic             out_prdy,
  output logic [WIDTH-1:0] out_pd,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic push, pop, stored;
  assign stored = count_q != '0;
  assign in_prdy = count_q != (AW+1)'(DEPTH);
  assign count = count_q;
`ifdef NV_BLKBOX_PIPE_BYPASS_EN
  // an empty buffer forwards the upstream word and only stores it if downstream stalls
  always_comb begin
    out_pvld = stored || in_pvld;
    out_pd = stored ? mem_q[rd_ptr_q] : (in_pvld ? in_pd : '0);
    push = in_pvld && in_prdy && !(!stored && out_prdy);
    pop = stored && out_prdy;
  end
`else
  // output always comes from storage, giving one cycle of latency
  always_comb begin
    out_pvld = stored;
    out_pd = stored ? mem_q[rd_ptr_q] : '0;
    push = in_pvld && in_prdy;
    pop = stored && out_prdy;
  end
`endif
  // next-state pointers and occupancy
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  // pointer and count registers; a reset cycle discards any transfer
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  // payload storage, left unreset
  always_ff @(posedge nvdla_core_clk) begin
    if (push && !nvdla_core_rst) mem_q[wr_ptr_q] <= in_pd;
  end
endmodule

// File: tb/tb_nv_blkbox_pipe_rcv.sv
// tb_nv_blkbox_pipe_rcv: directed self-checking bench for nv_blkbox_pipe_rcv
module tb_nv_blkbox_pipe_rcv;
  logic clk = 1'b0, rst = 1'b1, in_pvld = 1'b0, out_prdy = 1'b0;
  logic in_prdy, out_pvld;
  logic [31:0] in_pd = '0, out_pd;
  logic [2:0] count;
  int vectors = 0, miscompares = 0;

  nv_blkbox_pipe_rcv #(.WIDTH(32), .DEPTH(4)) dut (
    .nvdla_core_clk(clk), .nvdla_core_rst(rst), .in_pvld(in_pvld), .in_prdy(in_prdy),
    .in_pd(in_pd), .out_pvld(out_pvld), .out_prdy(out_prdy), .out_pd(out_pd), .count(count)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_pvld = 1'b0; out_prdy = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("reset in_prdy", 32'(in_prdy), 32'd1);
    chk("reset out_pvld", 32'(out_pvld), 32'd0);
    chk("reset out_pd", out_pd, 32'd0);
    chk("reset count", 32'(count), 32'd0);
  endtask

  task automatic test_fill_drain;
    out_prdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_pvld = 1'b1; in_pd = 32'hA0 + 32'(i);
      step();
      chk("fill count", 32'(count), 32'(i + 1));
    end
    chk("full in_prdy", 32'(in_prdy), 32'd0);
    in_pd = 32'hA4;
    step();
    chk("full hold count", 32'(count), 32'd4);
    chk("full hold in_prdy", 32'(in_prdy), 32'd0);
    in_pvld = 1'b0; out_prdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain out_pvld", 32'(out_pvld), 32'd1);
      chk("drain out_pd", out_pd, 32'hA0 + 32'(i));
      step();
      if (i == 0) begin
        chk("drain in_prdy reopen", 32'(in_prdy), 32'd1);
        chk("drain count after first pop", 32'(count), 32'd3);
      end
    end
    chk("drained count", 32'(count), 32'd0);
    chk("drained out_pvld", 32'(out_pvld), 32'd0);
  endtask

  task automatic test_streaming;
    out_prdy = 1'b1; in_pvld = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      in_pd = 32'(i);
`ifdef NV_BLKBOX_PIPE_BYPASS_EN
      #1;
      chk("stream bypass out_pd", out_pd, 32'(i));
      chk("stream bypass count", 32'(count), 32'd0);
      step();
`else
      step();
      chk("stream out_pd", out_pd, 32'(i));
      chk("stream count", 32'(count), 32'd1);
      chk("stream out_pvld", 32'(out_pvld), 32'd1);
`endif
    end
    in_pvld = 1'b0;
    step();
    chk("stream end count", 32'(count), 32'd0);
  endtask

  task automatic test_back_to_back;
    out_prdy = 1'b0; in_pvld = 1'b1;
    in_pd = 32'hB0; step();
    in_pd = 32'hB1; step();
    chk("b2b count pre", 32'(count), 32'd2);
    out_prdy = 1'b1; in_pd = 32'hB2;
    chk("b2b out_pd 0", out_pd, 32'hB0);
    step();
    chk("b2b count 1", 32'(count), 32'd2);
    chk("b2b out_pd 1", out_pd, 32'hB1);
    in_pd = 32'hB3;
    step();
    chk("b2b count 2", 32'(count), 32'd2);
    chk("b2b out_pd 2", out_pd, 32'hB2);
    in_pvld = 1'b0;
    step();
    chk("b2b out_pd 3", out_pd, 32'hB3);
    chk("b2b count 3", 32'(count), 32'd1);
    step();
    chk("b2b count end", 32'(count), 32'd0);
  endtask

  task automatic test_reset_mid;
    out_prdy = 1'b0; in_pvld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_pd = 32'hC0 + 32'(i);
      step();
    end
    chk("mid count pre", 32'(count), 32'd3);
    in_pd = 32'hC3; rst = 1'b1;
    step();
    rst = 1'b0; in_pvld = 1'b0;
    #1;
    chk("mid count", 32'(count), 32'd0);
    chk("mid out_pvld", 32'(out_pvld), 32'd0);
    chk("mid out_pd", out_pd, 32'd0);
    chk("mid in_prdy", 32'(in_prdy), 32'd1);
    in_pvld = 1'b1; in_pd = 32'h55;
    step();
    in_pvld = 1'b0;
    #1;
    chk("mid first out", out_pd, 32'h55);
    chk("mid first count", 32'(count), 32'd1);
    out_prdy = 1'b1;
    step();
    chk("mid drain count", 32'(count), 32'd0);
  endtask

  task automatic test_empty;
    out_prdy = 1'b1; in_pvld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("empty out_pd", out_pd, 32'd0);
      chk("empty count", 32'(count), 32'd0);
      chk("empty out_pvld", 32'(out_pvld), 32'd0);
    end
  endtask

  task automatic test_latency;
    in_pvld = 1'b1; in_pd = 32'h77; out_prdy = 1'b1;
    #1;
`ifdef NV_BLKBOX_PIPE_BYPASS_EN
    chk("bypass out_pvld", 32'(out_pvld), 32'd1);
    chk("bypass out_pd", out_pd, 32'h77);
    step();
    chk("bypass count", 32'(count), 32'd0);
    out_prdy = 1'b0;
    #1;
    chk("bypass stall out_pd", out_pd, 32'h77);
    step();
    chk("bypass stall count", 32'(count), 32'd1);
`else
    chk("lat same-cycle out_pvld", 32'(out_pvld), 32'd0);
    chk("lat same-cycle out_pd", out_pd, 32'd0);
    step();
    chk("lat next out_pvld", 32'(out_pvld), 32'd1);
    chk("lat next out_pd", out_pd, 32'h77);
    chk("lat count", 32'(count), 32'd1);
`endif
    in_pvld = 1'b0; out_prdy = 1'b1;
    step();
    chk("lat drain count", 32'(count), 32'd0);
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_streaming();
    test_back_to_back();
    test_reset_mid();
    test_empty();
    test_latency();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
